adder_insta_amisha: RTL and testbench
=====================================

ADDER_INSTA_AMISHA -- requirements
Module: adder_insta_amisha

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter W4, default 4, giving the width of the narrow adder.
REQ-003 The block SHALL have parameter W8, default 8, giving the width of the wide adder.
REQ-004 Port clk_amisha SHALL be an input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port rst_n_amisha SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port a4_amisha SHALL be an input, W4 bits: narrow adder operand A, unsigned.
REQ-007 Port b4_amisha SHALL be an input, W4 bits: narrow adder operand B, unsigned.
REQ-008 Port sum4_amisha SHALL be an output, W4 bits: registered narrow sum.
REQ-009 Port c4_amisha SHALL be an output, 1 bit: registered narrow carry-out.
REQ-010 Port a8_amisha SHALL be an input, W8 bits: wide adder operand A, unsigned.
REQ-011 Port b8_amisha SHALL be an input, W8 bits: wide adder operand B, unsigned.
REQ-012 Port sum8_amisha SHALL be an output, W8 bits: registered wide sum.
REQ-013 Port c8_amisha SHALL be an output, 1 bit: registered wide carry-out.

Function
REQ-014 The block SHALL contain two instances of one parameterized ripple-carry adder submodule: one of width W4 and one of width W8.
REQ-015 The adder submodule SHALL be built from generated 1-bit full-adder instances, with a carry-in of 0.
REQ-016 The narrow path SHALL compute {c4, sum4} = a4 + b4 with W4+1-bit result precision; sum4 is the low W4 bits and c4 is the MSB.
REQ-017 The wide path SHALL compute {c8, sum8} = a8 + b8 with W8+1-bit result precision.
REQ-018 The two paths SHALL be fully independent, with no shared carry.
REQ-019 Each output register SHALL capture the adder result at every rising clock edge; latency is exactly 1 cycle, and a new operand pair is accepted every cycle with no handshake.
REQ-020 Overflow beyond the MSB SHALL wrap the sum modulo 2^W, with carry-out = 1 (for example F+F gives E with carry 1).
REQ-021 Operands that change between clock edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-022 While rst_n_amisha = 0, all outputs SHALL be 0 immediately, independent of the clock.
REQ-023 On reset deassertion, the first rising edge SHALL load the sum of the current operands.
REQ-024 Reset asserted mid-stream SHALL discard any in-flight result.

Configuration
REQ-025 When macro ADDER_INSTA_OVF_EN is defined, the block SHALL add the outputs ov4_amisha and ov8_amisha (1 bit each, registered, reset to 0), flagging two's-complement signed overflow: operand MSBs are equal and the sum MSB differs.
REQ-026 When ADDER_INSTA_OVF_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Reset check: assert rst_n_amisha = 0 mid-cycle with nonzero results held -> all outputs go to 0 at once; after release, the next edge loads the sums.
REQ-028 Narrow adder: a4 = 0 and b4 = 7 -> sum4 = 7, c4 = 0; a4 = 4 and b4 = C -> sum4 = 0, c4 = 1; a4 = D and b4 = 7 -> sum4 = 4, c4 = 1; a4 = F and b4 = F -> sum4 = E, c4 = 1; each appears one edge after it is applied.
REQ-029 Wide adder: B3 + 00 -> B3, c8 = 0; 4C + A4 -> F0, c8 = 0; B8 + 2B -> E3, c8 = 0; C3 + C3 -> 86, c8 = 1; F0 + 0F -> FF, c8 = 0.
REQ-030 Back-to-back streaming: change operands on every edge for 8 cycles -> each output equals the previous cycle's sum with no bubbles.
REQ-031 With ADDER_INSTA_OVF_EN defined: 7 + 1 (4-bit) -> ov4 = 1; 70 + 10 (8-bit) -> ov8 = 1; 4 + C -> ov4 = 0; C3 + C3 -> ov8 = 0.

Source files
------------

// File: rtl/adder_insta_amisha.sv
// Dual independent registered ripple-carry adders (W4-bit and W8-bit), 1-cycle latency.
// Define ADDER_INSTA_OVF_EN to add registered signed-overflow flags ov4_amisha/ov8_amisha.

module adder_insta_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_insta_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder_insta_fa u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .c_i  (carry[i]),
      .s_o  (sum_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o = carry[W];
endmodule

module adder_insta_amisha #(
  parameter int W4 = 4,
  parameter int W8 = 8
) (
  input  logic          clk_amisha,
  input  logic          rst_n_amisha,
  input  logic [W4-1:0] a4_amisha,
  input  logic [W4-1:0] b4_amisha,
  output logic [W4-1:0] sum4_amisha,
  output logic          c4_amisha,
`ifdef ADDER_INSTA_OVF_EN
  output logic          ov4_amisha,
  output logic          ov8_amisha,
`endif
  input  logic [W8-1:0] a8_amisha,
  input  logic [W8-1:0] b8_amisha,
  output logic [W8-1:0] sum8_amisha,
  output logic          c8_amisha
);
  logic [W4-1:0] sum4_d, sum4_q;
  logic          c4_d, c4_q;
  logic [W8-1:0] sum8_d, sum8_q;
  logic          c8_d, c8_q;

  adder_insta_rca #(.W(W4)) u_add4 (
    .a_i   (a4_amisha),
    .b_i   (b4_amisha),
    .sum_o (sum4_d),
    .co_o  (c4_d)
  );

  adder_insta_rca #(.W(W8)) u_add8 (
    .a_i   (a8_amisha),
    .b_i   (b8_amisha),
    .sum_o (sum8_d),
    .co_o  (c8_d)
  );

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      sum4_q <= '0;
      c4_q   <= 1'b0;
      sum8_q <= '0;
      c8_q   <= 1'b0;
    end else begin
      sum4_q <= sum4_d;
      c4_q   <= c4_d;
      sum8_q <= sum8_d;
      c8_q   <= c8_d;
    end
  end

  assign sum4_amisha = sum4_q;
  assign c4_amisha   = c4_q;
  assign sum8_amisha = sum8_q;
  assign c8_amisha   = c8_q;

`ifdef ADDER_INSTA_OVF_EN
  logic ov4_d, ov4_q;
  logic ov8_d, ov8_q;

  // Signed overflow: operands agree in sign but the result sign flips.
  assign ov4_d = (a4_amisha[W4-1] == b4_amisha[W4-1]) && (sum4_d[W4-1] != a4_amisha[W4-1]);
  assign ov8_d = (a8_amisha[W8-1] == b8_amisha[W8-1]) && (sum8_d[W8-1] != a8_amisha[W8-1]);

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      ov4_q <= 1'b0;
      ov8_q <= 1'b0;
    end else begin
      ov4_q <= ov4_d;
      ov8_q <= ov8_d;
    end
  end

  assign ov4_amisha = ov4_q;
  assign ov8_amisha = ov8_q;
`endif
endmodule

// File: tb/tb_adder_insta_amisha.sv
// Scoreboard bench for adder_insta_amisha: directed vectors with hand-computed sums,
// expected results queued by the driver and checked by an independent monitor.

module tb_adder_insta_amisha;
  logic       clk_amisha;
  logic       rst_n_amisha;
  logic [3:0] a4_amisha, b4_amisha, sum4_amisha;
  logic       c4_amisha;
  logic [7:0] a8_amisha, b8_amisha, sum8_amisha;
  logic       c8_amisha;
`ifdef ADDER_INSTA_OVF_EN
  logic       ov4_amisha, ov8_amisha;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] a4, b4, s4;
    logic       c4;
    logic [7:0] a8, b8, s8;
    logic       c8;
    logic       ov4, ov8;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] s4;
    logic       c4;
    logic [7:0] s8;
    logic       c8;
    logic       ov4, ov8;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];

  adder_insta_amisha #(.W4(4), .W8(8)) dut (
    .clk_amisha   (clk_amisha),
    .rst_n_amisha (rst_n_amisha),
    .a4_amisha    (a4_amisha),
    .b4_amisha    (b4_amisha),
    .sum4_amisha  (sum4_amisha),
    .c4_amisha    (c4_amisha),
`ifdef ADDER_INSTA_OVF_EN
    .ov4_amisha   (ov4_amisha),
    .ov8_amisha   (ov8_amisha),
`endif
    .a8_amisha    (a8_amisha),
    .b8_amisha    (b8_amisha),
    .sum8_amisha  (sum8_amisha),
    .c8_amisha    (c8_amisha)
  );

  initial clk_amisha = 1'b0;
  always #5 clk_amisha = ~clk_amisha;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sum4"}, 32'(sum4_amisha), 32'h0);
    check({tag, " c4"},   32'(c4_amisha),   32'h0);
    check({tag, " sum8"}, 32'(sum8_amisha), 32'h0);
    check({tag, " c8"},   32'(c8_amisha),   32'h0);
`ifdef ADDER_INSTA_OVF_EN
    check({tag, " ov4"},  32'(ov4_amisha),  32'h0);
    check({tag, " ov8"},  32'(ov8_amisha),  32'h0);
`endif
  endtask

  // Drive one vector and queue the result it should produce at the next edge.
  task automatic apply(input int id, input vec_t v);
    exp_t e;
    a4_amisha = v.a4;
    b4_amisha = v.b4;
    a8_amisha = v.a8;
    b8_amisha = v.b8;
    e.id  = id;
    e.s4  = v.s4;
    e.c4  = v.c4;
    e.s8  = v.s8;
    e.c8  = v.c8;
    e.ov4 = v.ov4;
    e.ov8 = v.ov8;
    sb_q.push_back(e);
  endtask

  // Monitor: anything queued before an edge must be visible just after it.
  always @(posedge clk_amisha) begin
    if (rst_n_amisha && sb_q.size() > 0) begin
      exp_t e;
      #1;
      e = sb_q.pop_front();
      check($sformatf("sum4[%0d]", e.id), 32'(sum4_amisha), 32'(e.s4));
      check($sformatf("c4[%0d]",   e.id), 32'(c4_amisha),   32'(e.c4));
      check($sformatf("sum8[%0d]", e.id), 32'(sum8_amisha), 32'(e.s8));
      check($sformatf("c8[%0d]",   e.id), 32'(c8_amisha),   32'(e.c8));
`ifdef ADDER_INSTA_OVF_EN
      check($sformatf("ov4[%0d]",  e.id), 32'(ov4_amisha),  32'(e.ov4));
      check($sformatf("ov8[%0d]",  e.id), 32'(ov8_amisha),  32'(e.ov8));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int spin;
    //           a4    b4    s4    c4    a8     b8     s8     c8    ov4   ov8
    vecs[0] = '{4'h0, 4'h7, 4'h7, 1'b0, 8'hB3, 8'h00, 8'hB3, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h4, 4'hC, 4'h0, 1'b1, 8'h4C, 8'hA4, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'hD, 4'h7, 4'h4, 1'b1, 8'hB8, 8'h2B, 8'hE3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'hF, 4'hF, 4'hE, 1'b1, 8'hC3, 8'hC3, 8'h86, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'h7, 4'h1, 4'h8, 1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 1'b0, 8'h70, 8'h10, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{4'h8, 4'h8, 4'h0, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{4'h9, 4'h3, 4'hC, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1};

    rst_n_amisha = 1'b0;
    a4_amisha = 4'h5;
    b4_amisha = 4'h6;
    a8_amisha = 8'h12;
    b8_amisha = 8'h34;
    repeat (3) @(posedge clk_amisha);
    #1;
    check_all_zero("reset_hold");

    // Release on a falling edge; the next rising edge must load the live operands.
    @(negedge clk_amisha);
    rst_n_amisha = 1'b1;
    apply(100, '{4'h5, 4'h6, 4'hB, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1, 1'b0});

    // Back-to-back streaming, one new vector every cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_amisha);
      apply(i, vecs[i]);
    end

    // Hold F+F / C3+C3 so the outputs are nonzero before the mid-cycle reset.
    @(negedge clk_amisha);
    apply(200, vecs[3]);
    @(negedge clk_amisha);
    apply(201, vecs[1]);
    #2;
    rst_n_amisha = 1'b0;
    sb_q.delete();
    #1;
    check_all_zero("reset_async");
    @(posedge clk_amisha);
    #1;
    check_all_zero("reset_discard");

    @(negedge clk_amisha);
    apply(300, vecs[2]);
    #2;
    rst_n_amisha = 1'b1;

    spin = 0;
    while (sb_q.size() > 0 && spin < 20) begin
      @(negedge clk_amisha);
      spin++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end

    repeat (2) @(negedge clk_amisha);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
